// File: rtl/fdiv_ctrl_if.sv
// Request/response and divider-side signal bundle for fdiv_ctrl.
// slave = controller side, master = requester/consumer/divider side.
interface fdiv_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_rm;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_q;
  logic [4:0]  res_flags;
  logic        div_fdiv;
  logic        div_ena;
  logic [23:0] div_a;
  logic [23:0] div_b;
  logic        div_busy;
  logic [31:0] div_q;

  modport slave (
    input  req_valid, req_a, req_b, req_rm, res_ready, div_busy, div_q,
    output req_ready, res_valid, res_q, res_flags, div_fdiv, div_ena, div_a, div_b
  );

  modport master (
    output req_valid, req_a, req_b, req_rm, res_ready, div_busy, div_q,
    input  req_ready, res_valid, res_q, res_flags, div_fdiv, div_ena, div_a, div_b
  );
endinterface

// File: rtl/fdiv_ctrl.sv
// Single-precision divide controller: special-case decode, divider issue, normalize/round.
// Latency T+2+DIV_LAT to res_valid (T+1 for specials when FDIV_SPECIAL_BYPASS_EN is defined).
// One op outstanding; req_ready low until the response handshake, result held while res_ready=0.
module fdiv_ctrl #(
  parameter int DIV_LAT = 19
) (
  input  logic  clk,
  input  logic  rst,
  fdiv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ROUND, RESP} state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic [1:0]  rm;
    logic        spec;
    logic [31:0] spec_q;
    logic [4:0]  spec_flags;
  } op_t;

  localparam int              CW     = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0]   LAT_LD = CW'(DIV_LAT);
  localparam logic [CW-1:0]   CNT_1  = CW'(1);
  localparam logic [31:0]     QNAN   = 32'h7FC0_0000;
  localparam logic [1:0]      RM_RNE = 2'd0;
  localparam logic [1:0]      RM_RZ  = 2'd1;
  localparam logic [1:0]      RM_RDN = 2'd2;
  localparam logic [1:0]      RM_RUP = 2'd3;

  state_t        state, state_n;
  op_t           op, dec;
  logic [CW-1:0] cnt;
  logic [31:0]   q_r;
  logic [31:0]   res_q_r;
  logic [4:0]    res_flags_r;

  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Operand decode; denormals collapse to signed zero without raising NX.
  always_comb begin
    a_exp  = bus.req_a[30:23];
    b_exp  = bus.req_b[30:23];
    a_frac = bus.req_a[22:0];
    b_frac = bus.req_b[22:0];
    a_zero = (a_exp == 8'd0);
    b_zero = (b_exp == 8'd0);
    a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
    a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

    dec      = '0;
    dec.sign = bus.req_a[31] ^ bus.req_b[31];
    dec.ea   = a_exp;
    dec.eb   = b_exp;
    dec.fa   = a_frac;
    dec.fb   = b_frac;
    dec.rm   = bus.req_rm;

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      dec.spec       = 1'b1;
      dec.spec_q     = QNAN;
      dec.spec_flags = 5'b10000;
    end else if (b_zero && !a_inf) begin
      dec.spec       = 1'b1;
      dec.spec_q     = {dec.sign, 8'hFF, 23'd0};
      dec.spec_flags = 5'b01000;
    end else if (a_inf) begin
      dec.spec       = 1'b1;
      dec.spec_q     = {dec.sign, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      dec.spec       = 1'b1;
      dec.spec_q     = {dec.sign, 31'd0};
    end
  end

  logic signed [9:0] e0, e1, e2;
  logic [22:0]       man;
  logic              grd, stk, inc;
  logic [23:0]       sum;
  logic [31:0]       rnd_q;
  logic [4:0]        rnd_flags;
  logic              to_inf;

  // Normalize the raw quotient, round, then clamp exponent range.
  always_comb begin
    e0 = $signed({2'b00, op.ea}) - $signed({2'b00, op.eb}) + 10'sd127;
    if (q_r[31]) begin
      man = q_r[30:8];
      grd = q_r[7];
      stk = |q_r[6:0];
      e1  = e0;
    end else begin
      man = q_r[29:7];
      grd = q_r[6];
      stk = |q_r[5:0];
      e1  = e0 - 10'sd1;
    end

    case (op.rm)
      RM_RNE:  inc = grd & (stk | man[0]);
      RM_RZ:   inc = 1'b0;
      RM_RDN:  inc = op.sign & (grd | stk);
      default: inc = ~op.sign & (grd | stk);
    endcase

    sum    = {1'b0, man} + {23'd0, inc};
    e2     = sum[23] ? (e1 + 10'sd1) : e1;
    to_inf = (op.rm == RM_RNE) || ((op.rm == RM_RUP) && !op.sign) ||
             ((op.rm == RM_RDN) && op.sign);

    if (e2 >= 10'sd255) begin
      rnd_q     = to_inf ? {op.sign, 8'hFF, 23'd0} : {op.sign, 31'h7F7F_FFFF};
      rnd_flags = 5'b00101;
    end else if (e2 <= 10'sd0) begin
      rnd_q     = {op.sign, 31'd0};
      rnd_flags = 5'b00011;
    end else begin
      rnd_q     = {op.sign, e2[7:0], sum[22:0]};
      rnd_flags = {4'b0000, grd | stk};
    end

    if (op.spec) begin
      rnd_q     = op.spec_q;
      rnd_flags = op.spec_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_q     = res_q_r;
    bus.res_flags = res_flags_r;
    bus.div_fdiv  = 1'b0;
    bus.div_ena   = 1'b0;
    bus.div_a     = 24'd0;
    bus.div_b     = 24'd0;
    case (state)
      IDLE: begin
        bus.req_ready = ~rst;
        if (bus.req_valid) begin
`ifdef FDIV_SPECIAL_BYPASS_EN
          state_n = dec.spec ? RESP : ISSUE;
`else
          state_n = ISSUE;
`endif
        end
      end
      ISSUE: begin
        bus.div_ena = 1'b1;
        bus.div_a   = {1'b1, op.fa};
        bus.div_b   = {1'b1, op.fb};
        if (!bus.div_busy) begin
          bus.div_fdiv = 1'b1;
          state_n      = WAIT;
        end
      end
      WAIT: begin
        bus.div_ena = 1'b1;
        if (cnt == CNT_1) state_n = ROUND;
      end
      ROUND: begin
        // Result is presented straight from the rounder in this cycle, then held in RESP.
        bus.res_valid = 1'b1;
        bus.res_q     = rnd_q;
        bus.res_flags = rnd_flags;
        state_n       = bus.res_ready ? IDLE : RESP;
      end
      RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op          <= '0;
      cnt         <= '0;
      q_r         <= '0;
      res_q_r     <= '0;
      res_flags_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op <= dec;
`ifdef FDIV_SPECIAL_BYPASS_EN
            if (dec.spec) begin
              res_q_r     <= dec.spec_q;
              res_flags_r <= dec.spec_flags;
            end
`endif
          end
        end
        ISSUE: if (!bus.div_busy) cnt <= LAT_LD;
        WAIT: begin
          cnt <= cnt - CNT_1;
          if (cnt == CNT_1) q_r <= bus.div_q;
        end
        ROUND: begin
          res_q_r     <= rnd_q;
          res_flags_r <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fdiv_ctrl.md
# fdiv_ctrl

Pipeline-side controller for the single-precision divide unit. It takes IEEE-754 operand pairs over a valid/ready request channel, resolves special cases, and feeds hidden-bit-extended mantissas to the Newton-Raphson divider. It then waits out the divider latency and normalizes and rounds the raw quotient. The packed result and exception flags are returned over a valid/ready response channel.

## Interface
- One clock; reset is synchronous and active-high.
- `DIV_LAT`, default 19: cycles from the `div_fdiv` cycle to the cycle in which `div_q` is valid.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_a` in 32: dividend, IEEE-754 single.
- `req_b` in 32: divisor, IEEE-754 single.
- `req_rm` in 2: rounding mode. 0 = RNE, 1 = RZ, 2 = RDN, 3 = RUP.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer takes the result.
- `res_q` out 32: quotient, IEEE-754 single.
- `res_flags` out 5: {NV, DZ, OF, UF, NX}.
- `div_fdiv` out 1: start pulse to the divider.
- `div_ena` out 1: divider pipeline enable.
- `div_a` out 24: dividend mantissa, format .1f.
- `div_b` out 24: divisor mantissa, format .1f.
- `div_busy` in 1: divider iterating.
- `div_q` in 32: raw quotient, format x.xxx…x. Bit 31 is the integer bit; bit 0 is the sticky bit.

## Operation
- States: IDLE, ISSUE, WAIT, ROUND, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, capture operands and `req_rm`, decode specials, then go to ISSUE.
- **Input decode**
  - Denormal inputs are treated as signed zero; NX is not set for this.
  - Result sign = sa ^ sb.
- **Special cases** (quiet NaN is 0x7FC00000):
  - NaN operand: quiet NaN, NV.
  - 0/0: quiet NaN, NV.
  - inf/inf: quiet NaN, NV.
  - x/0 with x finite and nonzero: signed inf, DZ.
  - inf/x: signed inf.
  - 0/x: signed zero.
  - x/inf: signed zero.
- **ISSUE**
  - Stay while `div_busy` = 1.
  - Otherwise drive `div_fdiv` = 1 for exactly one cycle, with `div_a` = {1, fa} and `div_b` = {1, fb}.
  - Load the wait counter with `DIV_LAT`, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - At count 1, register `div_q` and go to ROUND.
- `div_ena` = 1 in ISSUE and WAIT, and 0 otherwise.
- **ROUND: exponent and mantissa selection**
  - Exponent e = ea − eb + 127, computed as a 10-bit signed value.
  - If q[31] = 1: mantissa = q[30:8], guard = q[7], sticky = |q[6:0].
  - Otherwise: mantissa = q[29:7], guard = q[6], sticky = |q[5:0], and e is decremented by 1.
- **ROUND: rounding**
  - Increment rules:
    - RNE: guard & (sticky | lsb).
    - RZ: never.
    - RDN: sign & (guard | sticky).
    - RUP: !sign & (guard | sticky).
  - NX = guard | sticky.
  - Mantissa carry-out increments e.
- **ROUND: range handling**
  - e ≥ 255: OF and NX are set. The result is inf under RNE, toward-inf RUP (positive) and RDN (negative); otherwise it is ±0x7F7FFFFF.
  - e ≤ 0: flush to signed zero, with UF and NX set.
- **RESP**
  - `res_valid` = 1.
  - `res_q` and `res_flags` stay stable until `res_valid` & `res_ready`, then return to IDLE.
- Reset values: all outputs 0, and the state is IDLE.
- Reset mid-operation discards any in-flight quotient. A later ISSUE still honours `div_busy`.

## Timing
- Request accepted at edge T (IDLE, handshake).
- Divider path, with `div_busy` = 0:
  - `div_fdiv` is high during cycle T+1.
  - `div_q` is sampled in cycle T+1+DIV_LAT.
  - `res_valid` rises in cycle T+2+DIV_LAT.
- Each cycle of `div_busy` = 1 in ISSUE adds one cycle.
- `req_ready` is low from T+1 until the response handshake completes.
- A new request can be accepted in the cycle after the response handshake.
- Only one operation is outstanding at a time.

## Configuration
- `FDIV_SPECIAL_BYPASS_EN` defined:
  - Special-case operations go IDLE→RESP, with `res_valid` at T+1.
  - `div_fdiv` is never pulsed for them.
- `FDIV_SPECIAL_BYPASS_EN` undefined:
  - Every operation takes the full ISSUE/WAIT path.
  - The divider result is overridden by the special value in ROUND.
  - `res_valid` is at T+2+DIV_LAT.

## Test plan
- 0x40C00000 / 0x40000000, RNE → `res_q` 0x40400000, flags 0, `res_valid` at T+2+DIV_LAT, and exactly one `div_fdiv` pulse.
- 0x3F800000 / 0x40400000 → RNE gives 0x3EAAAAAB with NX; RZ gives 0x3EAAAAAA with NX.
- Special cases:
  - 0x3F800000 / 0x00000000 → 0x7F800000 with DZ.
  - 0x00000000 / 0x00000000 → 0x7FC00000 with NV.
  - Both at T+1 with bypass, or T+2+DIV_LAT without.
- Range cases:
  - 0x7F000000 / 0x3E800000 → RNE gives 0x7F800000 with OF|NX; RZ gives 0x7F7FFFFF.
  - 0x00800000 / 0x4B000000 → 0x00000000 with UF|NX.
- Backpressure: hold `res_ready` = 0 for 5 cycles. `res_q` and `res_flags` must stay stable and `req_ready` must stay 0. A request is accepted in the cycle after the handshake.
- Hold `div_busy` = 1 for 3 cycles in ISSUE: `div_fdiv` fires on the 4th cycle. Then assert `rst` mid-WAIT: all outputs are 0 next cycle, and a following 6.0/2.0 request returns 0x40400000.
